// File: rtl/mcu_pkg.sv
// Core-wide constants and types shared by the program-counter logic.
package mcu_pkg;

    localparam int PC_W        = 11;
    localparam int STACK_DEPTH = 16;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1;

    localparam logic [PC_W-1:0] RESET_VEC = 11'h000;
    localparam logic [PC_W-1:0] IRQ_VEC   = 11'h004;

    // Where the next fetch address comes from.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_IRQ  = 3'd1,
        SRC_RET  = 3'd2,
        SRC_CALL = 3'd3,
        SRC_JUMP = 3'd4,
        SRC_PCL  = 3'd5
    } pc_src_e;

endpackage

// File: rtl/stack_depth_mon.sv
// Shadow occupancy counter for the call stack. The stack wraps silently,
// so over/underflow are detected here and latched as sticky flags.
module stack_depth_mon
    import mcu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hold,
    input  logic               push,
    input  logic               pop,
    input  logic               clr_err,
    output logic [DEPTH_W-1:0] depth,
    output logic               stk_ovf,
    output logic               stk_unf
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Next occupancy and flags; a new error in the clearing cycle wins.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (!hold) begin
            if (clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (push) begin
                if (depth_q == DEPTH_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    depth_d = depth_q + 1'b1;
                end
            end else if (pop) begin
                if (depth_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    depth_d = depth_q - 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth   = depth_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-address selection. Drives push/pop/data into
// the hardware call stack and requests a fetch flush on any redirect.
module pc_sequencer
    import mcu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               irq_take,
    input  logic               ret,
    input  logic               call,
    input  logic               jump,
    input  logic [PC_W-1:0]    target,
    input  logic               pcl_wr,
    input  logic [7:0]         pcl_data,
    input  logic [4:0]         pclath,
    input  logic               skip,
    input  logic               clr_err,
    input  logic [PC_W-1:0]    stack_top,
    output logic [PC_W-1:0]    pc,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [PC_W-1:0]    stack_din,
    output logic               flush,
    output logic [DEPTH_W-1:0] depth,
    output logic               stk_ovf,
    output logic               stk_unf
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            accept;
    logic            redirect;
    pc_src_e         src;
    logic            unused_pclath;

    // Only the low three PCLATH bits reach the 11-bit program counter.
    assign unused_pclath = ^pclath[4:3];

    // An event is acted on only out of reset and while not stalled.
    assign accept   = reset_n & ~stall;
    assign redirect = irq_take | ret | call | jump | pcl_wr | skip;

    // Stack strobes; an interrupt pre-empts a return, a return pre-empts a call.
    assign stack_push = (irq_take | (call & ~ret)) & accept;
    assign stack_pop  = ret & ~irq_take & accept;
    assign stack_din  = pc_q;

    // Priority select of the next-pc source and flush request.
    always_comb begin
        src     = SRC_SEQ;
        pc_d    = pc_q;
        flush_d = 1'b0;
        if (irq_take) begin
            src = SRC_IRQ;
        end else if (ret) begin
            src = SRC_RET;
        end else if (call) begin
            src = SRC_CALL;
        end else if (jump) begin
            src = SRC_JUMP;
        end else if (pcl_wr) begin
            src = SRC_PCL;
        end
        if (accept) begin
            flush_d = redirect;
            case (src)
                SRC_IRQ:  pc_d = IRQ_VEC;
                SRC_RET:  pc_d = stack_top;
                SRC_CALL: pc_d = target;
                SRC_JUMP: pc_d = target;
                SRC_PCL:  pc_d = {pclath[2:0], pcl_data};
                default:  pc_d = pc_q + 1'b1;   // sequential and skip; wraps
            endcase
        end
    end

    // PC and flush registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign pc    = pc_q;
    assign flush = flush_q;

    stack_depth_mon u_depth_mon (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (stall),
        .push    (stack_push),
        .pop     (stack_pop),
        .clr_err (clr_err),
        .depth   (depth),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
    );

endmodule
